// File: rtl/capture_rect_if.sv
// ---------------------------------------------------------------------------
// vga_if -- pixel stream bundle shared by the capture_rect input and output.
//
// Signals
//   hcount [11:0]  current pixel column
//   vcount [11:0]  current pixel row
//   hsync, vsync   sync pulses
//   hblnk, vblnk   blanking flags (1 = pixel not visible)
//   rgb    [11:0]  pixel colour
//
// Modports
//   in   consumer view (all signals are inputs)
//   out  producer view (all signals are outputs)
// ---------------------------------------------------------------------------
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/capture_rect.sv
// ---------------------------------------------------------------------------
// capture_rect -- grabs one W x H rectangle of pixels out of a VGA stream and
// emits it as a sequence of memory writes, while passing the stream through
// with one clock of delay.
//
// A start pulse (accepted only when idle) latches the window origin (x, y).
// The block then waits for the top-left pixel of the next frame, captures
// every visible pixel inside the window during that frame, and pulses done
// when the bottom-right window pixel has been written or when the frame ends
// first (truncated = 1).
//
// Parameters
//   W  window width in pixels  (1..64)
//   H  window height in pixels (1..64)
//
// Ports
//   clk        pixel clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle capture request
//   x, y       window left column / top row, sampled on an accepted start
//   vga_in     incoming pixel stream
//   vga_out    the same stream, registered once
//   wr_en      write strobe, aligned with vga_out
//   wr_addr    {row[5:0], col[5:0]} inside the window; 0 when wr_en = 0
//   wr_data    pixel colour; 0 when wr_en = 0
//   busy       waiting for a frame or capturing
//   done       one-cycle end-of-capture pulse
//   truncated  last capture ended at frame end; held until the next start
// ---------------------------------------------------------------------------
module capture_rect #(
  parameter int W = 48,
  parameter int H = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] x,
  input  logic [11:0] y,
  vga_if.in           vga_in,
  vga_if.out          vga_out,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        truncated
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Window bounds are evaluated with one extra bit so x_l + W and y_l + H
  // cannot wrap around the 12-bit coordinate space.
  localparam logic [12:0] W13 = 13'(W);
  localparam logic [12:0] H13 = 13'(H);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [11:0] r_x_l;
  logic [11:0] r_y_l;
  logic        r_truncated;

  logic        r_wr_en;
  logic [11:0] r_wr_addr;
  logic [11:0] r_wr_data;

  logic [11:0] r_hcount;
  logic [11:0] r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_hblnk;
  logic        r_vblnk;
  logic [11:0] r_rgb;

  logic [12:0] w_hc;
  logic [12:0] w_vc;
  logic [12:0] w_x_lo;
  logic [12:0] w_y_lo;
  logic [12:0] w_x_hi;
  logic [12:0] w_y_hi;
  logic        w_in_win;
  logic        w_at_origin;
  logic        w_eval;
  logic        w_accept;
  logic        w_last_px;
  logic        w_latch;
  logic        w_trunc_set;
  logic [5:0]  w_row;
  logic [5:0]  w_col;

  // -------------------------------------------------------------------------
  // Window geometry
  // -------------------------------------------------------------------------
  assign w_hc   = {1'b0, vga_in.hcount};
  assign w_vc   = {1'b0, vga_in.vcount};
  assign w_x_lo = {1'b0, r_x_l};
  assign w_y_lo = {1'b0, r_y_l};
  assign w_x_hi = w_x_lo + W13;
  assign w_y_hi = w_y_lo + H13;

  assign w_in_win = !vga_in.hblnk && !vga_in.vblnk &&
                    (w_hc >= w_x_lo) && (w_hc < w_x_hi) &&
                    (w_vc >= w_y_lo) && (w_vc < w_y_hi);

  assign w_last_px = (w_hc == w_x_hi - 13'd1) && (w_vc == w_y_hi - 13'd1);

  assign w_at_origin = (vga_in.hcount == 12'd0) && (vga_in.vcount == 12'd0);

  // The frame-origin pixel that releases ARMED is itself a capture candidate,
  // so evaluation covers that cycle as well as the whole CAPTURE state.
  assign w_eval   = (r_state == S_CAPTURE) || ((r_state == S_ARMED) && w_at_origin);
  assign w_accept = w_eval && w_in_win;

  assign w_row = 6'(w_vc - w_y_lo);
  assign w_col = 6'(w_hc - w_x_lo);

  // -------------------------------------------------------------------------
  // FSM: next state and control strobes
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_trunc_set = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_latch     = 1'b1;
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (w_at_origin) begin
          // A window whose last pixel is the origin finishes immediately.
          if (w_accept && w_last_px) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (w_accept && w_last_px) begin
          w_state_nxt = S_DONE;
        end else if (vga_in.vblnk) begin
          // Capture began on a visible origin pixel, so the first vblnk seen
          // here is the rising edge that ends the frame.
          w_state_nxt = S_DONE;
          w_trunc_set = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM state, latched window origin and truncation flag
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x_l       <= '0;
      r_y_l       <= '0;
      r_truncated <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_x_l       <= x;
        r_y_l       <= y;
        r_truncated <= 1'b0;
      end else if (w_trunc_set) begin
        r_truncated <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Write port: one clock after the accepted pixel, zeroed when idle
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en   <= w_accept;
      r_wr_addr <= w_accept ? {w_row, w_col} : 12'd0;
      r_wr_data <= w_accept ? vga_in.rgb : 12'd0;
    end
  end

  // -------------------------------------------------------------------------
  // Stream pass-through, independent of the FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_hsync  <= 1'b0;
      r_vsync  <= 1'b0;
      r_hblnk  <= 1'b0;
      r_vblnk  <= 1'b0;
      r_rgb    <= '0;
    end else begin
      r_hcount <= vga_in.hcount;
      r_vcount <= vga_in.vcount;
      r_hsync  <= vga_in.hsync;
      r_vsync  <= vga_in.vsync;
      r_hblnk  <= vga_in.hblnk;
      r_vblnk  <= vga_in.vblnk;
      r_rgb    <= vga_in.rgb;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign vga_out.hcount = r_hcount;
  assign vga_out.vcount = r_vcount;
  assign vga_out.hsync  = r_hsync;
  assign vga_out.vsync  = r_vsync;
  assign vga_out.hblnk  = r_hblnk;
  assign vga_out.vblnk  = r_vblnk;
  assign vga_out.rgb    = r_rgb;

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = (r_state == S_ARMED) || (r_state == S_CAPTURE);
  assign done      = (r_state == S_DONE);
  assign truncated = r_truncated;

endmodule

// File: tb/tb_capture_rect.sv
// ---------------------------------------------------------------------------
// tb_capture_rect -- directed bench for capture_rect (W = 48, H = 64).
//
// A frame generator emits visible rows/columns followed by two hblank pixels
// per row and a short vblank line. Rows and columns far from the window may
// be skipped (the origin pixel is always kept) so large frames stay cheap;
// the design only looks at the counts and blanking flags of each pixel.
// Inputs are driven on the falling edge; the outputs sampled there reflect
// the pixel driven one cycle earlier.
// ---------------------------------------------------------------------------
module tb_capture_rect;

  localparam int W = 48;
  localparam int H = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] x;
  logic [11:0] y;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [11:0] wr_data;
  logic        busy;
  logic        done;
  logic        truncated;

  vga_if vin ();
  vga_if vout ();

  capture_rect #(.W(W), .H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x         (x),
    .y         (y),
    .vga_in    (vin),
    .vga_out   (vout),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .truncated (truncated)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    x;
    int    y;
    int    hv;         // visible width of the generated frame
    int    vv;         // visible height
    int    hs;         // columns 1..hs-1 skipped
    int    vs;         // rows 1..vs-1 skipped
    int    mode;       // rgb pattern: 0 = hcount, 1 = mixed
    int    exp_wr;
    int    exp_first;
    int    exp_last;
    int    exp_trunc;
    int    exp_coinc;  // done lands on a write cycle
  } vec_t;

  vec_t vecs [5];

  // Scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_wr, n_done, wr_err, zero_err, pipe_err, col_err;
  int first_addr, last_addr, trunc_at_done, done_with_wr;

  // Stimulus state
  int cx = 0, cy = 0, cur_mode = 0;
  int fidx = 0, start_at = -1, start_every = 0, abort_at = 0;
  bit start_on_done = 1'b0;

  // Previous driven pixel
  int          p_h, p_v;
  bit          p_hb, p_vb, p_hs, p_vs;
  logic [11:0] p_rgb;
  bit          p_rst = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_counters();
    n_wr = 0; n_done = 0; wr_err = 0; zero_err = 0; pipe_err = 0; col_err = 0;
    first_addr = -1; last_addr = -1; trunc_at_done = -1; done_with_wr = -1;
  endtask

  function automatic int out_nz();
    logic r;
    r = |{vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk,
          vout.rgb, wr_en, wr_addr, wr_data, busy, done, truncated};
    return (r === 1'b0) ? 0 : 1;
  endfunction

  task automatic monitor();
    bit          inwin;
    logic [11:0] ea;
    cyc++;
    if (rst_n && p_rst) begin
      if (vout.hcount !== 12'(p_h) || vout.vcount !== 12'(p_v) || vout.hsync !== p_hs ||
          vout.vsync !== p_vs || vout.hblnk !== p_hb || vout.vblnk !== p_vb ||
          vout.rgb !== p_rgb)
        pipe_err++;
    end
    if (wr_en === 1'b1) begin
      n_wr++;
      inwin = !p_hb && !p_vb && p_h >= cx && p_h < cx + W && p_v >= cy && p_v < cy + H;
      ea = 12'((((p_v - cy) & 63) << 6) | ((p_h - cx) & 63));
      if (!inwin || wr_addr !== ea || wr_data !== p_rgb) wr_err++;
      if (n_wr == 1) first_addr = int'(wr_addr);
      last_addr = int'(wr_addr);
      if (cur_mode == 0 && cx == 0 && wr_data !== {6'd0, wr_addr[5:0]}) col_err++;
    end else if (wr_en !== 1'b0 || wr_addr !== 12'd0 || wr_data !== 12'd0) begin
      zero_err++;
    end
    if (done === 1'b1) begin
      n_done++;
      trunc_at_done = int'(truncated);
      done_with_wr  = int'(wr_en);
    end
  endtask

  task automatic pix(input int h, input int v, input bit hb, input bit vb,
                     input bit hs, input bit vs);
    @(negedge clk);
    monitor();
    start = 1'b0;
    if (fidx == start_at) start = 1'b1;
    if (start_every > 0 && busy === 1'b1 && (cyc % start_every) == 0) start = 1'b1;
    if (start_on_done && done === 1'b1) start = 1'b1;
    if (fidx == start_at) begin
      x = 12'(cx);
      y = 12'(cy);
    end else begin
      x = 12'($urandom);
      y = 12'($urandom);
    end
    fidx++;
    p_h = h; p_v = v; p_hb = hb; p_vb = vb; p_hs = hs; p_vs = vs;
    p_rgb = (cur_mode == 0) ? 12'(h) : 12'((h + 37 * v) ^ 'h5A3);
    p_rst = rst_n;
    vin.hcount = 12'(h);
    vin.vcount = 12'(v);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.rgb    = p_rgb;
  endtask

  task automatic gen_frame(input int hv, input int vv, input int hs, input int vs,
                           input int st);
    fidx = 0;
    start_at = st;
    for (int v = 0; v < vv; v++) begin
      if (v != 0 && v < vs) continue;
      for (int h = 0; h < hv; h++) begin
        if (h != 0 && h < hs) continue;
        pix(h, v, 1'b0, 1'b0, 1'b0, 1'b0);
        if (abort_at > 0 && n_wr >= abort_at) begin
          start_at = -1;
          return;
        end
      end
      pix(hv, v, 1'b1, 1'b0, 1'b0, 1'b0);
      pix(hv + 1, v, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    for (int k = 0; k < 4; k++) pix(k, vv, 1'b0, 1'b1, 1'b0, k == 1);
    start_at = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"win100_50",   100,  50, 160, 120,  90,  40, 1, 3072, 'h000, 'hFEF, 0, 1};
    vecs[1] = '{"win0_0_hcnt",   0,   0,  48,  64,   0,   0, 0, 3072, 'h000, 'hFEF, 0, 1};
    vecs[2] = '{"win780_580",  780, 580, 800, 600, 770, 570, 1,  400, 'h000, 'h4D3, 1, 0};
    vecs[3] = '{"win4090_10", 4090,  10,  64,  32,   0,   0, 1,    0,     -1,    -1, 1, 0};
    vecs[4] = '{"win20_0_part", 20,   0,  64,  32,   0,   0, 1, 1408, 'h000, 'h7EB, 1, 0};

    // ---- Reset behaviour: outputs zero while inputs toggle, start ignored
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
    clear_counters();
    repeat (2) @(negedge clk);
    vin.hcount = 12'h123; vin.vcount = 12'h045; vin.hsync = 1'b1; vin.vsync = 1'b1;
    vin.hblnk = 1'b1; vin.vblnk = 1'b1; vin.rgb = 12'hABC; start = 1'b1; x = 12'h7;
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", out_nz(), 0);
    start = 1'b0;
    rst_n = 1'b1;
    clear_counters();
    cx = 0; cy = 0; cur_mode = 1;
    pix(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 12; i++) pix(i, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_writes", n_wr, 0);

    // ---- Table-driven window captures
    foreach (vecs[i]) begin
      cx = vecs[i].x; cy = vecs[i].y; cur_mode = vecs[i].mode;
      clear_counters();
      gen_frame(vecs[i].hv, vecs[i].vv, vecs[i].hs, vecs[i].vs, 1);
      check({vecs[i].name, "_frame0_writes"}, n_wr, 0);
      check({vecs[i].name, "_armed_busy"}, int'(busy), 1);
      clear_counters();
      gen_frame(vecs[i].hv, vecs[i].vv, vecs[i].hs, vecs[i].vs, -1);
      for (int k = 0; k < 3; k++) pix(vecs[i].hv + 2, vecs[i].vv, 1'b1, 1'b1, 1'b0, 1'b0);
      check({vecs[i].name, "_writes"}, n_wr, vecs[i].exp_wr);
      if (vecs[i].exp_wr > 0) begin
        check({vecs[i].name, "_first_addr"}, first_addr, vecs[i].exp_first);
        check({vecs[i].name, "_last_addr"}, last_addr, vecs[i].exp_last);
      end
      check({vecs[i].name, "_write_errors"}, wr_err, 0);
      check({vecs[i].name, "_idle_nonzero"}, zero_err, 0);
      check({vecs[i].name, "_vga_out_pipe"}, pipe_err, 0);
      check({vecs[i].name, "_done_pulses"}, n_done, 1);
      check({vecs[i].name, "_trunc_at_done"}, trunc_at_done, vecs[i].exp_trunc);
      check({vecs[i].name, "_done_on_write"}, done_with_wr, vecs[i].exp_coinc);
      check({vecs[i].name, "_trunc_held"}, int'(truncated), vecs[i].exp_trunc);
      check({vecs[i].name, "_busy_after"}, int'(busy), 0);
      if (vecs[i].mode == 0 && vecs[i].x == 0) check({vecs[i].name, "_data_eq_col"}, col_err, 0);
    end

    // ---- Extra starts while busy and a start in the done cycle
    cx = 0; cy = 0; cur_mode = 1;
    clear_counters();
    start_every = 37;
    gen_frame(48, 64, 0, 0, 1);
    check("multistart_frame0_writes", n_wr, 0);
    clear_counters();
    start_on_done = 1'b1;
    gen_frame(48, 64, 0, 0, -1);
    check("multistart_writes", n_wr, 3072);
    check("multistart_done_pulses", n_done, 1);
    check("multistart_write_errors", wr_err, 0);
    start_on_done = 1'b0;
    start_every = 0;
    check("multistart_busy_after", int'(busy), 0);
    clear_counters();
    gen_frame(48, 64, 0, 0, -1);
    check("multistart_next_frame_writes", n_wr, 0);
    check("multistart_next_frame_done", n_done, 0);
    check("multistart_next_frame_busy", int'(busy), 0);

    // ---- Asynchronous reset at the 1000th write
    cx = 0; cy = 0; cur_mode = 0;
    clear_counters();
    gen_frame(48, 64, 0, 0, 1);
    clear_counters();
    abort_at = 1000;
    gen_frame(48, 64, 0, 0, -1);
    abort_at = 0;
    check("abort_write_count", n_wr, 1000);
    check("abort_busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check("abort_async_outputs_zero", out_nz(), 0);
    for (int k = 0; k < 3; k++) pix(k + 1, 20, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_no_done", n_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_counters();
    gen_frame(48, 64, 0, 0, -1);
    check("abort_idle_writes", n_wr, 0);
    check("abort_idle_busy", int'(busy), 0);
    check("abort_idle_done", n_done, 0);
    gen_frame(48, 64, 0, 0, 1);
    clear_counters();
    gen_frame(48, 64, 0, 0, -1);
    check("abort_recapture_writes", n_wr, 3072);
    check("abort_recapture_done", n_done, 1);
    check("abort_recapture_errors", wr_err + zero_err + pipe_err + col_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_rect.md
CAPTURE_RECT -- requirements
Module: capture_rect

Interface
REQ-001 Parameter W, default 48, meaning capture window width in pixels, 1..64.
REQ-002 Parameter H, default 64, meaning capture window height in pixels, 1..64.
REQ-003 clk  input  1  pixel clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to capture one window from the next frame.
REQ-006 x  input  12  window left column, sampled only on an accepted start.
REQ-007 y  input  12  window top row, sampled only on an accepted start.
REQ-008 vga_in  vga_if.in  -  incoming stream: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb.
REQ-009 vga_out  vga_if.out  -  stream passed through unchanged, delayed by 1 clk.
REQ-010 wr_en  output  1  memory write strobe.
REQ-011 wr_addr  output  12  write address {row[5:0], col[5:0]}.
REQ-012 wr_data  output  12  pixel rgb to write.
REQ-013 busy  output  1  high in ARMED and CAPTURE.
REQ-014 done  output  1  one-cycle pulse when a capture finishes.
REQ-015 truncated  output  1  window was cut short by frame end; valid with done; held until the next accepted start.

Function
REQ-016 The FSM SHALL have the states IDLE, ARMED, CAPTURE and DONE.
REQ-017 In IDLE, start=1 SHALL latch x and y into x_l and y_l, clear truncated, and move to ARMED.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 ARMED SHALL move to CAPTURE on the cycle vga_in.hcount==0 and vga_in.vcount==0; that cycle is itself evaluated for capture.
REQ-020 A pixel SHALL be in-window when hblnk==0, vblnk==0, x_l<=hcount<x_l+W and y_l<=vcount<y_l+H.
REQ-021 All comparisons SHALL use at least 13-bit arithmetic, so x_l+W and y_l+H do not wrap.
REQ-022 In CAPTURE, an in-window pixel SHALL produce wr_en=1 on the next cycle.
REQ-023 In that cycle, wr_addr SHALL equal {6'(vcount-y_l), 6'(hcount-x_l)} and wr_data SHALL equal vga_in.rgb.
REQ-024 wr_en, wr_addr, wr_data and vga_out SHALL all be registered and mutually aligned, with exactly 1 clk latency from vga_in.
REQ-025 When wr_en=0, wr_addr and wr_data SHALL be 0.
REQ-026 CAPTURE SHALL move to DONE on the cycle the pixel (x_l+W-1, y_l+H-1) is accepted.
REQ-027 If vblnk rises in CAPTURE before that pixel, the FSM SHALL move to DONE and set truncated=1.
REQ-028 A window lying wholly or partly outside the visible area SHALL therefore finish truncated with the writes that fell inside it.
REQ-029 DONE SHALL assert done for exactly one cycle, coincident with the final wr_en of a full capture, then return to IDLE.
REQ-030 done and start in the same cycle SHALL not start a capture; start is accepted only from IDLE.
REQ-031 vga_out SHALL be a pure 1-clk copy of every vga_in field, independent of FSM state.

Reset
REQ-032 While rst_n=0, every output SHALL be 0 (vga_out fields, wr_en, wr_addr, wr_data, busy, done, truncated), x_l=y_l=0 and the FSM SHALL be IDLE.
REQ-033 Reset mid-capture SHALL abort the capture with no done pulse.
REQ-034 The first capture after rst_n deasserts SHALL need a new start.

Verification
REQ-035 x=100, y=50, W=48, H=64, start during frame 0 -> no writes in frame 0; 3072 writes in frame 1; first write addr 0x000 for pixel (100,50); last write addr 0xFEF for pixel (147,113); done coincides with the last write; truncated=0.
REQ-036 rgb=hcount[11:0] pattern, x=0, y=0 -> wr_data at addr {r,c} equals c for all 3072 writes; vga_out equals vga_in delayed exactly 1 clk.
REQ-037 x=780, y=580 on an 800x600 visible frame -> 20x20=400 writes; done at vblnk rise; truncated=1.
REQ-038 Extra start pulses while busy=1, plus a start in the done cycle -> exactly one capture; busy falls after done.
REQ-039 rst_n pulled low at the 1000th write -> all outputs 0 asynchronously; no done pulse; the FSM idles until the next start.
REQ-040 x=4090, y=10 -> no writes (no 12-bit wrap); done at vblnk with truncated=1.
